// File: rtl/pipe_ctrl_if.sv
// Control bundle between the hazard/memory side and the pipeline sequencer.
// master drives requests, slave (pipe_ctrl) returns per-stage controls.
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             stop;
   logic             br_taken;
   logic             mem_busy;
   logic             cnt_clr;
   logic             pc_we;
   logic             pc_sel;
   logic             if_id_we;
   logic             if_id_flush;
   logic             id_ex_we;
   logic             id_ex_flush;
   logic             ex_mem_we;
   logic             mem_wb_flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt_stall;
   logic [CNT_W-1:0] cnt_flush;
   logic [CNT_W-1:0] cnt_mwait;
   logic             err_stall;

   modport master (
      output stop, br_taken, mem_busy, cnt_clr,
      input  pc_we, pc_sel, if_id_we, if_id_flush,
      input  id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush,
      input  state, cnt_stall, cnt_flush, cnt_mwait, err_stall
   );

   modport slave (
      input  stop, br_taken, mem_busy, cnt_clr,
      output pc_we, pc_sel, if_id_we, if_id_flush,
      output id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush,
      output state, cnt_stall, cnt_flush, cnt_mwait, err_stall
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: stage enables, bubbles, next-PC select,
// wrong-path drain after redirects, saturating perf counters and stall watchdog.
module pipe_ctrl #(
   parameter int IMEM_LAT  = 1,
   parameter int STALL_MAX = 4,
   parameter int CNT_W     = 16
) (
   input logic   clk,
   input logic   rst_n,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      MWAIT   = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam int RW = $clog2(STALL_MAX + 1);

   state_t           r_state;
   logic [1:0]       r_drain;
   logic [RW-1:0]    r_run;
   logic [CNT_W-1:0] r_cnt_stall;
   logic [CNT_W-1:0] r_cnt_flush;
   logic [CNT_W-1:0] r_cnt_mwait;
   logic             r_err;

   logic w_mb, w_br, w_dr, w_st;

   // Drain is tracked by the slot count so a memory wait cannot lose it
   assign w_mb = bus.mem_busy;
   assign w_br = bus.br_taken & ~w_mb;
   assign w_dr = (r_drain != 2'd0) & ~w_mb & ~bus.br_taken;
   assign w_st = bus.stop & ~w_mb & ~bus.br_taken & (r_drain == 2'd0);

   always_comb begin
      bus.pc_we        = 1'b1;
      bus.pc_sel       = 1'b0;
      bus.if_id_we     = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_we     = 1'b1;
      bus.id_ex_flush  = 1'b0;
      bus.ex_mem_we    = 1'b1;
      bus.mem_wb_flush = 1'b0;
      if (!rst_n) begin
         bus.pc_we        = 1'b0;
         bus.if_id_we     = 1'b0;
         bus.id_ex_we     = 1'b0;
         bus.ex_mem_we    = 1'b0;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_flush  = 1'b1;
         bus.mem_wb_flush = 1'b1;
      end else begin
         unique case (1'b1)
            w_mb: begin
               bus.pc_we        = 1'b0;
               bus.if_id_we     = 1'b0;
               bus.id_ex_we     = 1'b0;
               bus.ex_mem_we    = 1'b0;
               bus.mem_wb_flush = 1'b1;
            end
            w_br: begin
               bus.pc_sel      = 1'b1;
               bus.if_id_flush = 1'b1;
               bus.id_ex_flush = 1'b1;
            end
            w_dr: begin
               bus.if_id_flush = 1'b1;
            end
            w_st: begin
               bus.pc_we       = 1'b0;
               bus.if_id_we    = 1'b0;
               bus.id_ex_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_drain     <= 2'd0;
         r_run       <= '0;
         r_cnt_stall <= '0;
         r_cnt_flush <= '0;
         r_cnt_mwait <= '0;
         r_err       <= 1'b0;
      end else begin
         unique case (1'b1)
            w_mb: begin
               r_state <= MWAIT;
            end
            w_br: begin
               r_state <= DRAIN;
               r_drain <= 2'(IMEM_LAT);
               r_run   <= '0;
            end
            w_dr: begin
               r_state <= (r_drain == 2'd1) ? RUN : DRAIN;
               r_drain <= r_drain - 2'd1;
               r_run   <= '0;
            end
            w_st: begin
               r_state <= LDSTALL;
               if (int'(r_run) < STALL_MAX)
                  r_run <= r_run + 1'b1;
            end
            default: begin
               r_state <= RUN;
               r_run   <= '0;
            end
         endcase

         if (bus.cnt_clr)
            r_err <= 1'b0;
         else if (w_st && (int'(r_run) + 1 >= STALL_MAX))
            r_err <= 1'b1;

         if (bus.cnt_clr) begin
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
            r_cnt_mwait <= '0;
         end else begin
            if (w_st && !(&r_cnt_stall))
               r_cnt_stall <= r_cnt_stall + 1'b1;
            if (w_br && !(&r_cnt_flush))
               r_cnt_flush <= r_cnt_flush + 1'b1;
            if (w_mb && !(&r_cnt_mwait))
               r_cnt_mwait <= r_cnt_mwait + 1'b1;
         end
      end
   end

   assign bus.state     = r_state;
   assign bus.cnt_stall = r_cnt_stall;
   assign bus.cnt_flush = r_cnt_flush;
   assign bus.cnt_mwait = r_cnt_mwait;
   assign bus.err_stall = r_err;
endmodule
